// File: rtl/vlc_tx_pkg.sv
// vlc_tx_pkg: shared states, defaults and Manchester chip helper for the VLC transmitter
package vlc_tx_pkg;

    typedef enum logic [1:0] {IDLE, POP, WAIT, SHIFT} state_e;

    localparam logic       DEF_IDLE_LEVEL    = 1'b0;
    localparam logic [7:0] DEF_PREAMBLE_BYTE = 8'h55;

    function automatic logic manchester_chip(input logic b, input logic phase);
        return phase ? b : ~b;
    endfunction

endpackage

// File: rtl/vlc_chip_timer.sv
// vlc_chip_timer: free-running chip-period counter with first/last-cycle strobes and sync restart
module vlc_chip_timer #(
    parameter int CLKS_PER_CHIP = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic chip_first,
    output logic chip_last
);

    localparam int W = $clog2(CLKS_PER_CHIP);

    logic [W-1:0] cnt_q, cnt_d;

    assign chip_first = cnt_q == '0;
    assign chip_last  = cnt_q == W'(CLKS_PER_CHIP - 1);
    assign cnt_d      = (restart || chip_last) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vlc_manchester_tx.sv
// vlc_manchester_tx: byte-buffer to Manchester LED serializer with prefetch; define VLC_TX_PREAMBLE_EN to lead each frame with PREAMBLE_BYTE
module vlc_manchester_tx
    import vlc_tx_pkg::*;
#(
    parameter int         CLKS_PER_CHIP = 50,
    parameter logic       IDLE_LEVEL    = DEF_IDLE_LEVEL,
    parameter logic [7:0] PREAMBLE_BYTE = DEF_PREAMBLE_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       data_avail,
    input  logic [7:0] data_in,
    output logic       pop,
    output logic       led_out,
    output logic       busy,
    output logic       frame_start
);

`ifdef VLC_TX_PREAMBLE_EN
    localparam logic PRE_EN = 1'b1;
`else
    localparam logic PRE_EN = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d, hold_q, hold_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       hold_valid_q, hold_valid_d;
    logic       phase_q, phase_d;
    logic       cap_q, cap_d;
    logic       pop_q, pop_d;
    logic       led_q, led_d;
    logic       busy_q, busy_d;
    logic       fs_q, fs_d;
    logic       chip_first, chip_last, go, pf;
    logic [7:0] first_byte;

    vlc_chip_timer #(.CLKS_PER_CHIP(CLKS_PER_CHIP)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .restart    (state_q != SHIFT),
        .chip_first (chip_first),
        .chip_last  (chip_last)
    );

    assign go         = enable && data_avail;
    assign pf         = state_q == SHIFT && chip_first && !phase_q && bit_idx_q == 3'd0 && !hold_valid_q && go;
    assign first_byte = PRE_EN ? PREAMBLE_BYTE : data_in;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_idx_d    = bit_idx_q;
        phase_d      = phase_q;
        led_d        = led_q;
        busy_d       = busy_q;
        pop_d        = 1'b0;
        fs_d         = 1'b0;
        cap_d        = pop_q && state_q == SHIFT;
        if (cap_q) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
        end
        case (state_q)
            IDLE: if (go) begin
                state_d = POP;
                pop_d   = 1'b1;
                busy_d  = 1'b1;
            end
            POP: state_d = WAIT;
            WAIT: begin
                state_d      = SHIFT;
                fs_d         = 1'b1;
                bit_idx_d    = 3'd7;
                phase_d      = 1'b0;
                shift_d      = first_byte;
                hold_d       = data_in;
                hold_valid_d = PRE_EN;
                led_d        = manchester_chip(first_byte[7], 1'b0);
            end
            SHIFT: begin
                pop_d = pf;
                if (chip_last) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        led_d = manchester_chip(shift_q[7], 1'b1);
                    end else if (bit_idx_q != 3'd0) begin
                        shift_d   = shift_q << 1;
                        bit_idx_d = bit_idx_q - 1'b1;
                        led_d     = manchester_chip(shift_q[6], 1'b0);
                    end else if (hold_valid_q) begin
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        bit_idx_d    = 3'd7;
                        led_d        = manchester_chip(hold_q[7], 1'b0);
                    end else begin
                        state_d = IDLE;
                        led_d   = IDLE_LEVEL;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bit_idx_q    <= '0;
            phase_q      <= 1'b0;
            cap_q        <= 1'b0;
            pop_q        <= 1'b0;
            led_q        <= IDLE_LEVEL;
            busy_q       <= 1'b0;
            fs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bit_idx_q    <= bit_idx_d;
            phase_q      <= phase_d;
            cap_q        <= cap_d;
            pop_q        <= pop_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            fs_q         <= fs_d;
        end
    end

    assign pop         = pop_q;
    assign led_out     = led_q;
    assign busy        = busy_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vlc_manchester_tx.sv
// tb_vlc_manchester_tx: scoreboard bench streaming hand-computed chip patterns through a buffer model
module tb_vlc_manchester_tx;

    localparam int CPC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       data_avail = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       pop, led_out, busy, frame_start;

    int   checks = 0, errors = 0, pops = 0, exp_pops = 0;
    logic exp_q[$];
    logic [7:0] buf_q[$];
    bit   in_frame = 1'b0, prev_pop = 1'b0;

    always #5 clk = ~clk;

    vlc_manchester_tx #(.CLKS_PER_CHIP(CPC), .IDLE_LEVEL(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .data_avail  (data_avail),
        .data_in     (data_in),
        .pop         (pop),
        .led_out     (led_out),
        .busy        (busy),
        .frame_start (frame_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_chips(input logic [15:0] c);
        for (int i = 15; i >= 0; i--) repeat (CPC) exp_q.push_back(c[i]);
    endtask

    task automatic frame_hdr();
`ifdef VLC_TX_PREAMBLE_EN
        push_chips(16'h9999);
`endif
    endtask

    task automatic give(input logic [7:0] b);
        buf_q.push_back(b);
        data_avail = 1'b1;
    endtask

    task automatic wait_fs(input int lim);
        int n = 0;
        while (!frame_start && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) check("frame_start_timeout", 1, 0);
    endtask

    task automatic wait_frame(input string name, input int lim);
        int n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) check({name, "_timeout"}, 1, 0);
        @(negedge clk);
        check({name, "_pops"}, pops, exp_pops);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin : buffer_model
        logic p;
        forever begin
            @(negedge clk);
            p = pop;
            @(posedge clk);
            #1;
            if (p && buf_q.size() > 0) begin
                data_in    = buf_q.pop_front();
                data_avail = buf_q.size() > 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            prev_pop = 1'b0;
        end else begin
            if (pop) begin
                pops++;
                check("pop_back_to_back", prev_pop, 0);
            end
            prev_pop = pop;
            if (frame_start) begin
                check("frame_start_dup", in_frame, 0);
                in_frame = 1'b1;
            end
            if (in_frame) begin
                if (busy) begin
                    if (exp_q.size() == 0) check("extra_chip", 1, 0);
                    else check("led_chip", led_out, exp_q.pop_front());
                end else begin
                    check("frame_len", exp_q.size(), 0);
                    check("idle_led", led_out, 0);
                    in_frame = 1'b0;
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_pop", pop, 0);
        check("rst_led", led_out, 0);
        check("rst_busy", busy, 0);
        check("rst_fs", frame_start, 0);
        rst = 1'b0;
        @(negedge clk);

        frame_hdr();
        push_chips(16'h6699);
        exp_pops++;
        give(8'hA5);
        enable = 1'b1;
        wait_frame("t1_a5", 400);

        frame_hdr();
        push_chips(16'hAAAA);
        push_chips(16'h5555);
        exp_pops += 2;
        give(8'h00);
        give(8'hFF);
        wait_frame("t2_00ff", 600);

        frame_hdr();
        push_chips(16'hAA55);
        exp_pops++;
        give(8'h0F);
        wait_fs(50);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_led", led_out, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_pop", pop, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        frame_hdr();
        push_chips(16'h6AA9);
        exp_pops++;
        give(8'h81);
        @(negedge clk);
        rst = 1'b0;
        wait_frame("t4_after_rst", 600);

        frame_hdr();
        push_chips(16'h5AA5);
        exp_pops++;
        give(8'hC3);
        give(8'hA5);
        give(8'hFF);
        wait_fs(50);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        wait_frame("t5_enable_drop", 600);
        buf_q.delete();
        data_avail = 1'b0;

        enable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            check("t6_led", led_out, 0);
        end
        check("t6_pops", pops, exp_pops);
        check("t6_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
